// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage and the load/store unit.
//   req_valid  : request present (master -> slave)
//   req_ready  : unit can accept (slave -> master)
//   req_op     : 000 LW, 001 SW, 010 LB, 011 LBU, 100 SB, 101 LH, 110 LHU, 111 SH
//   req_base   : base register value
//   req_offset : sign-extended immediate
//   req_wdata  : store data (low byte/half used for SB/SH)
//   resp_valid : one-cycle response pulse
//   resp_data  : extended load data, 0 for stores and errors
//   resp_err   : misaligned or out-of-range access, valid with resp_valid
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_base, req_offset, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_base, req_offset, req_wdata,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one request at a time, computes the
// effective address, performs word/half/byte loads with sign or zero
// extension, and sub-word stores by read-modify-write through the data cache
// wrapper, which samples on the falling edge of clk.
//   clk, rst         : clock, synchronous active-high reset
//   lsu              : request/response channel (slave side)
//   mem_enable       : cache wrapper enable
//   mem_write_enable : cache wrapper write enable (only with mem_enable)
//   mem_address      : word index, zero-extended
//   mem_wdata        : cache wrapper input data
//   mem_rdata        : cache wrapper output data
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave lsu,
  output logic             mem_enable,
  output logic             mem_write_enable,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, MERGE, RESP} state_e;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_SW  = 3'b001,
    OP_LB  = 3'b010,
    OP_LBU = 3'b011,
    OP_SB  = 3'b100,
    OP_LH  = 3'b101,
    OP_LHU = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        mem_enable_q, mem_enable_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Request decode
  op_e         req_op;
  logic [31:0] ea;
  logic [31:0] index;
  logic        misaligned;
  logic        out_of_range;

  assign req_op = op_e'(lsu.req_op);
  assign ea     = lsu.req_base + lsu.req_offset;
  assign index  = {2'b00, ea[31:2]};
  assign out_of_range = (index >> ADDR_WIDTH) != '0;

  always_comb begin
    misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         misaligned = (ea[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = ea[0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Lane extraction for loads and lane insertion for sub-word stores
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        sub_word_store;

  assign sub_word_store = (op_q == OP_SB) || (op_q == OP_SH);

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (lane_q)
      2'd0: rd_byte = mem_rdata[7:0];
      2'd1: rd_byte = mem_rdata[15:8];
      2'd2: rd_byte = mem_rdata[23:16];
      2'd3: rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_ext = mem_rdata;
    case (op_q)
      OP_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_ext = {24'h000000, rd_byte};
      OP_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_ext = {16'h0000, rd_half};
      default: load_ext = mem_rdata;
    endcase

    merged = mem_rdata;
    if (op_q == OP_SB) begin
      case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (op_q == OP_SH) begin
      if (lane_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Next-state and next-output logic. Response outputs are loaded on the edge
  // leaving RESP, so resp_valid is high during the first IDLE cycle.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    result_d      = result_q;
    err_d         = err_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
    mem_enable_d  = mem_enable_q;
    mem_we_d      = mem_we_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (lsu.req_valid) begin
          op_d        = req_op;
          lane_d      = ea[1:0];
          wdata_d     = lsu.req_wdata;
          result_d    = '0;
          err_d       = misaligned | out_of_range;
          req_ready_d = 1'b0;
          if (misaligned || out_of_range) begin
            state_d = RESP;
          end else if (req_op == OP_SW) begin
            mem_enable_d  = 1'b1;
            mem_we_d      = 1'b1;
            mem_address_d = index;
            mem_wdata_d   = lsu.req_wdata;
            state_d       = WRITE;
          end else begin
            mem_enable_d  = 1'b1;
            mem_we_d      = 1'b0;
            mem_address_d = index;
            state_d       = READ;
          end
        end
      end
      READ: begin
        if (sub_word_store) begin
          mem_wdata_d = merged;
          mem_we_d    = 1'b1;
          state_d     = MERGE;
        end else begin
          result_d     = load_ext;
          mem_enable_d = 1'b0;
          state_d      = RESP;
        end
      end
      WRITE, MERGE: begin
        mem_enable_d = 1'b0;
        mem_we_d     = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        resp_data_d  = result_q;
        resp_err_d   = err_q;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        mem_enable_d = 1'b0;
        mem_we_d     = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_LW;
      lane_q        <= '0;
      wdata_q       <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      mem_enable_q  <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      result_q      <= result_d;
      err_q         <= err_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
      mem_enable_q  <= mem_enable_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign lsu.req_ready    = req_ready_q;
  assign lsu.resp_valid   = resp_valid_q;
  assign lsu.resp_data    = resp_data_q;
  assign lsu.resp_err     = resp_err_q;
  assign mem_enable       = mem_enable_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_address_q;
  assign mem_wdata        = mem_wdata_q;

endmodule
